// File: rtl/flash_playback_sequencer_if.sv
// Avalon-MM read-only bus between the playback sequencer and the parallel flash.
// The sequencer is the master; the flash controller (or a bench model) is the slave.
interface flash_playback_sequencer_if #(
  parameter int ADDR_W = 23
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic [3:0]        byteenable;

  modport master (
    output address, read, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/flash_playback_sequencer.sv
// Steps a (word, half-word) sample pointer through flash on each sample tick,
// fetching a new 32-bit word only when the buffered one is used up.
module flash_playback_sequencer #(
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(23'h7FFFF)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        play,
  input  logic                        reverse,
  input  logic                        restart,
  input  logic                        sample_tick,
  flash_playback_sequencer_if.master  flsh,
  output logic [15:0]                 audio_out,
  output logic                        audio_valid,
  output logic                        busy,
  output logic                        missed_tick
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, EMIT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              half_reg;
  logic [31:0]       word_buf_reg;
  logic              buf_valid_reg;
  logic              restart_pend_reg;
  logic [15:0]       audio_out_reg;
  logic              audio_valid_reg;
  logic              missed_tick_reg;

  logic [ADDR_W-1:0] step_addr;
  logic              step_half;
  logic              step_keep;
  logic [ADDR_W-1:0] restart_addr;

  assign flsh.address    = addr_reg;
  assign flsh.read       = (state_reg == REQ);
  assign flsh.byteenable = 4'b1111;
  assign audio_out       = audio_out_reg;
  assign audio_valid     = audio_valid_reg;
  assign missed_tick     = missed_tick_reg;
  assign busy            = (state_reg != IDLE);
  assign restart_addr    = reverse ? LAST_ADDR : '0;

  // Crossing a word boundary in either direction invalidates the buffer.
  always_comb begin
    step_addr = addr_reg;
    step_half = ~half_reg;
    step_keep = 1'b1;
    if (!reverse && half_reg) begin
      step_addr = (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_W'(1);
      step_keep = 1'b0;
    end else if (reverse && !half_reg) begin
      step_addr = (addr_reg == '0) ? LAST_ADDR : addr_reg - ADDR_W'(1);
      step_keep = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (restart || restart_pend_reg) state_next = IDLE;
        else if (sample_tick && play)    state_next = buf_valid_reg ? EMIT : REQ;
      end
      REQ:  if (!flsh.waitrequest) state_next = flsh.readdatavalid ? EMIT : WAIT;
      WAIT: if (flsh.readdatavalid)  state_next = EMIT;
      EMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg         <= '0;
      half_reg         <= 1'b0;
      word_buf_reg     <= '0;
      buf_valid_reg    <= 1'b0;
      restart_pend_reg <= 1'b0;
      audio_out_reg    <= '0;
      audio_valid_reg  <= 1'b0;
      missed_tick_reg  <= 1'b0;
    end else begin
      audio_valid_reg <= 1'b0;
      missed_tick_reg <= sample_tick && (state_reg != IDLE);
      // A restart mid-fetch is deferred so the bus transaction still completes.
      if (restart && (state_reg != IDLE)) restart_pend_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (restart || restart_pend_reg) begin
            addr_reg         <= restart_addr;
            half_reg         <= reverse;
            buf_valid_reg    <= 1'b0;
            restart_pend_reg <= 1'b0;
          end
        end
        REQ: begin
          if (!flsh.waitrequest && flsh.readdatavalid) begin
            word_buf_reg  <= flsh.readdata;
            buf_valid_reg <= 1'b1;
          end
        end
        WAIT: begin
          if (flsh.readdatavalid) begin
            word_buf_reg  <= flsh.readdata;
            buf_valid_reg <= 1'b1;
          end
        end
        EMIT: begin
          if (restart_pend_reg) begin
            addr_reg         <= restart_addr;
            half_reg         <= reverse;
            buf_valid_reg    <= 1'b0;
            restart_pend_reg <= 1'b0;
          end else begin
            audio_out_reg   <= half_reg ? word_buf_reg[31:16] : word_buf_reg[15:0];
            audio_valid_reg <= 1'b1;
            addr_reg        <= step_addr;
            half_reg        <= step_half;
            if (!step_keep) buf_valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_playback_sequencer.sv
// Directed bench for flash_playback_sequencer with a 4-word flash model (LAST_ADDR = 3).
module tb_flash_playback_sequencer;

  logic        clk;
  logic        rst;
  logic        play;
  logic        reverse;
  logic        restart;
  logic        sample_tick;
  logic [15:0] audio_out;
  logic        audio_valid;
  logic        busy;
  logic        missed_tick;

  int vec_cnt = 0;
  int err_cnt = 0;

  flash_playback_sequencer_if #(.ADDR_W(23)) flsh ();

  flash_playback_sequencer #(.ADDR_W(23), .LAST_ADDR(23'd3)) dut (
    .clk         (clk),
    .rst         (rst),
    .play        (play),
    .reverse     (reverse),
    .restart     (restart),
    .sample_tick (sample_tick),
    .flsh        (flsh.master),
    .audio_out   (audio_out),
    .audio_valid (audio_valid),
    .busy        (busy),
    .missed_tick (missed_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash slave model: waitrequest for wr_cfg cycles per request, data latency cycles after accept.
  logic [31:0] mem [4];
  int          wr_cfg   = 0;
  int          latency  = 2;
  int          wr_left  = 0;
  int          lat_left = 0;
  logic        pending  = 1'b0;
  logic [31:0] pend_data = '0;
  logic        rdv_r    = 1'b0;
  logic [31:0] rdata_r  = '0;
  logic [22:0] acc_q [$];

  assign flsh.waitrequest   = flsh.read && (wr_left != 0);
  assign flsh.readdatavalid = rdv_r;
  assign flsh.readdata      = rdata_r;

  always @(posedge clk) begin
    rdv_r <= 1'b0;
    if (!flsh.read) wr_left <= wr_cfg;
    else if (wr_left != 0) wr_left <= wr_left - 1;
    if (pending) begin
      if (lat_left <= 1) begin
        rdv_r   <= 1'b1;
        rdata_r <= pend_data;
        pending <= 1'b0;
      end else begin
        lat_left <= lat_left - 1;
      end
    end
    if (flsh.read && !flsh.waitrequest) begin
      pending   <= 1'b1;
      lat_left  <= latency;
      pend_data <= mem[flsh.address[1:0]];
      acc_q.push_back(flsh.address);
    end
  end

  // Output monitor: every cycle with audio_valid / missed_tick high is recorded.
  int          av_cnt = 0;
  int          mt_cnt = 0;
  logic [15:0] av_q [$];

  always @(negedge clk) begin
    if (audio_valid) begin
      av_cnt++;
      av_q.push_back(audio_out);
    end
    if (missed_tick) mt_cnt++;
  end

  task automatic do_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic play_one(output bit ok);
    do_tick();
    wait_idle(ok);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vec_cnt++; if (flsh.address !== 23'd0) begin err_cnt++; $display("FAIL reset_address got %0h want 0", flsh.address); end
    vec_cnt++; if (flsh.read !== 1'b0) begin err_cnt++; $display("FAIL reset_read got %b want 0", flsh.read); end
    vec_cnt++; if (flsh.byteenable !== 4'hF) begin err_cnt++; $display("FAIL reset_byteenable got %h want f", flsh.byteenable); end
    vec_cnt++; if (audio_out !== 16'h0) begin err_cnt++; $display("FAIL reset_audio_out got %h want 0", audio_out); end
    vec_cnt++; if (audio_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_audio_valid got %b want 0", audio_valid); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    vec_cnt++; if (missed_tick !== 1'b0) begin err_cnt++; $display("FAIL reset_missed_tick got %b want 0", missed_tick); end
    rst = 1'b1;
    @(negedge clk);
    $display("reset: outputs checked");
  endtask

  task automatic test_forward();
    logic [15:0] exp_v [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    logic [22:0] exp_a [2] = '{23'd0, 23'd1};
    int a0 = av_q.size();
    int c0 = acc_q.size();
    bit ok;
    play = 1'b1;
    do_tick();
    vec_cnt++; if (flsh.read !== 1'b1 || flsh.address !== 23'd0) begin err_cnt++; $display("FAIL fwd_first_req got read=%b addr=%0h want read=1 addr=0", flsh.read, flsh.address); end
    wait_idle(ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL fwd_timeout got busy want idle"); end
    do_tick();
    vec_cnt++; if (audio_valid !== 1'b0 || busy !== 1'b1) begin err_cnt++; $display("FAIL fwd_emit_cycle got valid=%b busy=%b want valid=0 busy=1", audio_valid, busy); end
    @(negedge clk);
    vec_cnt++; if (audio_valid !== 1'b1 || audio_out !== 16'hBBBB) begin err_cnt++; $display("FAIL fwd_buf_latency got valid=%b out=%h want valid=1 out=bbbb", audio_valid, audio_out); end
    @(negedge clk);
    play_one(ok);
    play_one(ok);
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (av_q.size() <= a0 + i || av_q[a0 + i] !== exp_v[i]) begin
        err_cnt++; $display("FAIL fwd_sample%0d got %h want %h", i, (av_q.size() > a0 + i) ? av_q[a0 + i] : 16'hxxxx, exp_v[i]);
      end
    end
    vec_cnt++; if (acc_q.size() != c0 + 2) begin err_cnt++; $display("FAIL fwd_accept_count got %0d want 2", acc_q.size() - c0); end
    for (int i = 0; i < 2; i++) begin
      vec_cnt++;
      if (acc_q.size() <= c0 + i || acc_q[c0 + i] !== exp_a[i]) begin err_cnt++; $display("FAIL fwd_accept_addr%0d want %0h", i, exp_a[i]); end
    end
    $display("forward: 4 samples, %0d fetches", acc_q.size() - c0);
  endtask

  task automatic test_wrap();
    logic [15:0] exp_v [9] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hAAAA};
    logic [22:0] exp_a [5] = '{23'd0, 23'd1, 23'd2, 23'd3, 23'd0};
    int a0, c0;
    bit ok;
    reverse = 1'b0;
    do_restart();
    a0 = av_q.size();
    c0 = acc_q.size();
    for (int i = 0; i < 9; i++) play_one(ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL wrap_timeout got busy want idle"); end
    for (int i = 0; i < 9; i++) begin
      vec_cnt++;
      if (av_q.size() <= a0 + i || av_q[a0 + i] !== exp_v[i]) begin err_cnt++; $display("FAIL wrap_sample%0d want %h", i, exp_v[i]); end
    end
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (acc_q.size() <= c0 + i || acc_q[c0 + i] !== exp_a[i]) begin err_cnt++; $display("FAIL wrap_accept_addr%0d want %0h", i, exp_a[i]); end
    end
    $display("wrap: 9 samples, %0d fetches", acc_q.size() - c0);
  endtask

  task automatic test_reverse();
    logic [15:0] exp_v [9] = '{16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h4444};
    logic [22:0] exp_a [5] = '{23'd3, 23'd2, 23'd1, 23'd0, 23'd3};
    int a0, c0, v0;
    bit ok;
    reverse = 1'b1;
    v0 = av_cnt;
    do_restart();
    @(negedge clk);
    vec_cnt++; if (av_cnt != v0 || flsh.address !== 23'd3) begin err_cnt++; $display("FAIL rev_restart got emits=%0d addr=%0h want emits=0 addr=3", av_cnt - v0, flsh.address); end
    a0 = av_q.size();
    c0 = acc_q.size();
    for (int i = 0; i < 9; i++) play_one(ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL rev_timeout got busy want idle"); end
    for (int i = 0; i < 9; i++) begin
      vec_cnt++;
      if (av_q.size() <= a0 + i || av_q[a0 + i] !== exp_v[i]) begin err_cnt++; $display("FAIL rev_sample%0d want %h", i, exp_v[i]); end
    end
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (acc_q.size() <= c0 + i || acc_q[c0 + i] !== exp_a[i]) begin err_cnt++; $display("FAIL rev_accept_addr%0d want %0h", i, exp_a[i]); end
    end
    // Direction flip mid-word: buffered low half of word 3 plays without a refetch.
    reverse = 1'b0;
    c0 = acc_q.size();
    play_one(ok);
    vec_cnt++; if (av_q[av_q.size() - 1] !== 16'h3333 || acc_q.size() != c0) begin err_cnt++; $display("FAIL rev_flip got %h fetches=%0d want 3333 fetches=0", av_q[av_q.size() - 1], acc_q.size() - c0); end
    $display("reverse: 10 samples checked");
  endtask

  task automatic test_waitrequest();
    int a0, c0;
    bit ok;
    reverse = 1'b0;
    do_restart();
    a0 = av_cnt;
    c0 = acc_q.size();
    wr_cfg = 5;
    do_tick();
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (flsh.read !== 1'b1 || flsh.waitrequest !== 1'b1 || flsh.address !== 23'd0) begin
        err_cnt++; $display("FAIL wait_hold%0d got read=%b wr=%b addr=%0h want 1 1 0", i, flsh.read, flsh.waitrequest, flsh.address);
      end
      @(negedge clk);
    end
    vec_cnt++; if (flsh.read !== 1'b1 || flsh.waitrequest !== 1'b0) begin err_cnt++; $display("FAIL wait_accept got read=%b wr=%b want 1 0", flsh.read, flsh.waitrequest); end
    wr_cfg = 0;
    wait_idle(ok);
    vec_cnt++; if (av_cnt != a0 + 1 || av_q[av_q.size() - 1] !== 16'hAAAA) begin err_cnt++; $display("FAIL wait_emit got emits=%0d out=%h want 1 aaaa", av_cnt - a0, av_q[av_q.size() - 1]); end
    vec_cnt++; if (acc_q.size() != c0 + 1) begin err_cnt++; $display("FAIL wait_accepts got %0d want 1", acc_q.size() - c0); end
    $display("waitrequest: 5-cycle stall, single emit");
  endtask

  task automatic test_missed_tick();
    int a0, m0;
    bit ok;
    do_restart();
    a0 = av_cnt;
    m0 = mt_cnt;
    do_tick();
    @(negedge clk);
    vec_cnt++; if (busy !== 1'b1 || flsh.read !== 1'b0) begin err_cnt++; $display("FAIL miss_in_wait got busy=%b read=%b want 1 0", busy, flsh.read); end
    do_tick();
    wait_idle(ok);
    vec_cnt++; if (mt_cnt != m0 + 1) begin err_cnt++; $display("FAIL miss_pulse got %0d cycles want 1", mt_cnt - m0); end
    vec_cnt++; if (av_cnt != a0 + 1 || av_q[av_q.size() - 1] !== 16'hAAAA) begin err_cnt++; $display("FAIL miss_emit got emits=%0d out=%h want 1 aaaa", av_cnt - a0, av_q[av_q.size() - 1]); end
    $display("missed_tick: %0d pulse(s)", mt_cnt - m0);
  endtask

  task automatic test_restart_wait();
    int a0, c0;
    bit ok;
    do_restart();
    a0 = av_cnt;
    c0 = acc_q.size();
    do_tick();
    @(negedge clk);
    do_restart();
    wait_idle(ok);
    vec_cnt++; if (av_cnt != a0) begin err_cnt++; $display("FAIL rst_wait_emit got %0d emits want 0", av_cnt - a0); end
    vec_cnt++; if (flsh.address !== 23'd0 || acc_q.size() != c0 + 1) begin err_cnt++; $display("FAIL rst_wait_ptr got addr=%0h fetches=%0d want 0 1", flsh.address, acc_q.size() - c0); end
    play_one(ok);
    vec_cnt++; if (acc_q.size() != c0 + 2 || acc_q[acc_q.size() - 1] !== 23'd0 || av_q[av_q.size() - 1] !== 16'hAAAA) begin
      err_cnt++; $display("FAIL rst_wait_next got fetches=%0d out=%h want 2 aaaa", acc_q.size() - c0, av_q[av_q.size() - 1]);
    end
    $display("restart during wait: data discarded");
  endtask

  task automatic test_reset_mid_fetch();
    int c0;
    bit ok;
    play_one(ok);
    wr_cfg = 3;
    do_tick();
    vec_cnt++; if (flsh.read !== 1'b1 || flsh.address !== 23'd1) begin err_cnt++; $display("FAIL arst_pre got read=%b addr=%0h want 1 1", flsh.read, flsh.address); end
    rst = 1'b0;
    #1;
    vec_cnt++; if (flsh.read !== 1'b0 || flsh.address !== 23'd0 || busy !== 1'b0) begin err_cnt++; $display("FAIL arst_now got read=%b addr=%0h busy=%b want 0 0 0", flsh.read, flsh.address, busy); end
    vec_cnt++; if (audio_out !== 16'h0 || audio_valid !== 1'b0 || missed_tick !== 1'b0) begin err_cnt++; $display("FAIL arst_audio got out=%h valid=%b missed=%b want 0 0 0", audio_out, audio_valid, missed_tick); end
    wr_cfg = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    c0 = acc_q.size();
    play_one(ok);
    vec_cnt++; if (acc_q.size() != c0 + 1 || acc_q[acc_q.size() - 1] !== 23'd0 || audio_out !== 16'hAAAA) begin
      err_cnt++; $display("FAIL arst_resume got fetches=%0d out=%h want 1 aaaa", acc_q.size() - c0, audio_out);
    end
    $display("async reset mid-fetch: resumed at word 0");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[0] = 32'hBBBB_AAAA;
    mem[1] = 32'hDDDD_CCCC;
    mem[2] = 32'h2222_1111;
    mem[3] = 32'h4444_3333;
    rst = 1'b0;
    play = 1'b0;
    reverse = 1'b0;
    restart = 1'b0;
    sample_tick = 1'b0;
    test_reset();
    test_forward();
    test_wrap();
    test_reverse();
    test_waitrequest();
    test_missed_tick();
    test_restart_wait();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/flash_playback_sequencer.md
# flash_playback_sequencer

Sequences 16-bit audio samples out of the 32-bit parallel flash for the audio player. On each sample-clock tick it steps a sample pointer (word address plus half-word select) forward or backward with wrap-around, fetches a new flash word over the Avalon-MM read interface only when the buffered word is used up, and presents the selected half-word to the audio register. It replaces ad-hoc address inc/dec/rst pulses with one owner of the flash address and read sequencing.

## Interface
- ADDR_W, 23, flash word-address width
- LAST_ADDR, 23'h7FFFF, highest word address played; wrap point
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- play  in  1  level; 1 = consume sample ticks, 0 = paused
- reverse  in  1  level; 0 = forward playback, 1 = backward
- restart  in  1  one-cycle pulse; jump to start of track for current direction
- sample_tick  in  1  one-cycle pulse from sample-rate divider
- flsh_address  out  ADDR_W  word address, registered
- flsh_read  out  1  Avalon read request
- flsh_waitrequest  in  1  Avalon wait request
- flsh_readdata  in  32  Avalon read data
- flsh_readdatavalid  in  1  Avalon read data valid
- flsh_byteenable  out  4  constant 4'b1111
- audio_out  out  16  current sample, registered
- audio_valid  out  1  one-cycle pulse when audio_out updates
- busy  out  1  combinational; 1 when state != IDLE
- missed_tick  out  1  one-cycle pulse: tick dropped while busy

## Operation
- Registers: addr[ADDR_W-1:0], half (0 = bits 15:0, 1 = bits 31:16), word_buf[31:0], buf_valid, restart_pend, state.
- Pointer (addr, half) names the next sample to play. flsh_address = addr at all times.
- Forward step: half 0 -> half 1; half 1 -> half 0, addr = (addr == LAST_ADDR) ? 0 : addr+1, buf_valid = 0.
- Reverse step: half 1 -> half 0; half 0 -> half 1, addr = (addr == 0) ? LAST_ADDR : addr-1, buf_valid = 0.
- reverse may change at any time; it only affects the next step taken. No refetch: the current word stays valid.
- Restart action: addr = reverse ? LAST_ADDR : 0, half = reverse ? 1 : 0, buf_valid = 0, restart_pend = 0. No audio_valid.
- States:
  - IDLE: if restart or restart_pend -> apply restart, stay IDLE (a same-cycle tick is ignored, no missed_tick). Else if sample_tick & play: buf_valid -> EMIT, otherwise -> REQ. Tick with play=0: ignored.
  - REQ: flsh_read = 1, held until a cycle with flsh_waitrequest = 0; then -> WAIT. If flsh_readdatavalid is also 1 in that cycle, latch the data and go -> EMIT.
  - WAIT: on flsh_readdatavalid, word_buf <= flsh_readdata, buf_valid <= 1, -> EMIT.
  - EMIT (1 cycle): if restart_pend, apply restart, no emit. Otherwise audio_out <= half ? word_buf[31:16] : word_buf[15:0], audio_valid <= 1, take one step. -> IDLE.
- restart while state != IDLE: set restart_pend. REQ still completes (flsh_read is never dropped while waitrequest = 1), and the returned data is discarded at EMIT.
- sample_tick while state != IDLE: missed_tick pulses next cycle, and the tick is dropped (not queued).
- play falling mid-fetch: the fetch completes and the sample is emitted.

## Timing
- Reset values: state IDLE, addr 0, half 0, buf_valid 0, restart_pend 0, word_buf 0, audio_out 0, audio_valid 0, flsh_read 0, missed_tick 0; busy 0.
- Buffered sample: tick at cycle T -> EMIT at T+1 -> audio_valid high at T+2.
- Flash sample: tick at T -> flsh_read high from T+1. Data accepted at cycle R (readdatavalid) -> EMIT at R+1 -> audio_valid at R+2.
- Forward, play held: flash read once per two ticks. Ticks must be at least (fetch latency + 3) cycles apart, otherwise missed_tick.
- audio_valid and missed_tick are exactly one cycle wide. audio_out holds its value between pulses.
- Async reset mid-fetch drops flsh_read immediately. Any later readdatavalid is ignored in IDLE.

## Test plan
- Forward, flash word 0 = 32'hBBBB_AAAA, word 1 = 32'hDDDD_CCCC, waitrequest 0, latency 2: four ticks -> audio_out AAAA, BBBB, CCCC, DDDD; exactly 2 flsh_read accepts, at addresses 0 and 1.
- Wrap: restart with reverse=0, then force the pointer to LAST_ADDR half 1 by stepping (use LAST_ADDR=3 in the bench) -> after word 3 high, the next fetch is address 0, low half.
- Reverse: reverse=1, restart, ticks -> fetch LAST_ADDR, emit [31:16] then [15:0], next fetch LAST_ADDR-1; at address 0 half 0 the following fetch is LAST_ADDR.
- waitrequest held 1 for 5 cycles in REQ -> flsh_read and flsh_address stable all 5 cycles; accepted on the 6th; single emit.
- Tick during WAIT -> missed_tick one pulse, one audio_valid only; restart during WAIT -> no audio_valid, pointer = (0,0) after EMIT, next tick fetches address 0.
- Assert rst low during REQ -> all outputs at reset values within the same cycle; play resumes from address 0 low half.
